fetch_unit: RTL and testbench

Instruction fetch stage and producer of the IF_ID pipeline register consumed by the decode stage. It holds the fetch PC, issues word requests to instruction memory over a valid/ready request channel and a valid-only response channel, and delivers {pc, fetched_inst, do_not_execute} to decode. It inserts bubbles when no instruction is available, holds its output when decode stalls, and flushes on jump redirects from execute.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared pipeline stage register types, bubble constant and fetch FSM encoding.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fetched_inst;
        logic        do_not_execute;
    } if_id_t;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DISCARD
    } fetch_state_e;

    function automatic if_id_t bubble(input logic [31:0] pc);
        return '{pc: pc, fetched_inst: NOP_INST, do_not_execute: 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request (valid/ready) and response (valid-only) channels.
interface fetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, one-outstanding imem requests and the IF_ID register feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    output if_id_t            if_id_r
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  pend;
    logic         hs;

    assign imem.req_valid = (state == FETCH_REQ) && !reset;
    assign imem.req_addr  = fetch_pc;
    assign hs             = imem.req_valid && imem.req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_REQ;
            fetch_pc <= RESET_PC;
            pend     <= '0;
            if_id_r  <= bubble(32'h0);
        end else if (redirect_valid) begin
            // a request still in flight must have its response swallowed
            fetch_pc <= redirect_pc & ~32'h3;
            pend     <= '0;
            if_id_r  <= bubble(fetch_pc);
            state    <= ((state == FETCH_REQ) && hs) ||
                        ((state == FETCH_WAIT || state == FETCH_DISCARD) && !imem.rsp_valid)
                        ? FETCH_DISCARD : FETCH_REQ;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (hs) state <= FETCH_WAIT;
                    if (!stall) if_id_r <= bubble(fetch_pc);
                end
                FETCH_WAIT: begin
                    if (imem.rsp_valid && stall) begin
                        pend  <= imem.rsp_data;
                        state <= FETCH_HOLD;
                    end else if (imem.rsp_valid) begin
                        if_id_r  <= '{pc: fetch_pc, fetched_inst: imem.rsp_data, do_not_execute: 1'b0};
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= FETCH_REQ;
                    end else if (!stall) begin
                        if_id_r <= bubble(fetch_pc);
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        if_id_r  <= '{pc: fetch_pc, fetched_inst: pend, do_not_execute: 1'b0};
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= FETCH_REQ;
                    end
                end
                default: begin
                    if (imem.rsp_valid) state <= FETCH_REQ;
                    if (!stall) if_id_r <= bubble(fetch_pc);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a transaction-level fetch model and an imem responder.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 0;
    logic        reset = 1;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        stall = 0;
    if_id_t      if_id_r;

    fetch_unit_if imem();

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem(imem), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .if_id_r(if_id_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic ready_c = 1, spur_c = 0, ovr_c = 0;
    int   lat = 1;
    logic mem_busy = 0;
    int   mem_cnt = 0;
    logic [31:0] mem_addr = 0;

    logic [31:0] exp_pc = 0;
    if_id_t      exp_if;
    logic        good = 0, held = 0;
    logic [31:0] held_w = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // one clock: drive at negedge, capture the cycle, then update memory+model and compare after the edge
    task automatic step();
        logic c_reset, c_rv, c_hs, c_rsp, c_stall, c_redir, arrived;
        logic [31:0] c_addr, c_data, c_rpc;
        @(negedge clk);
        imem.req_ready = ready_c;
        imem.rsp_valid = (mem_busy && mem_cnt == 0) || (spur_c && !mem_busy);
        imem.rsp_data  = !mem_busy ? 32'hBAD0_BAD0 : ovr_c ? 32'hDEAD_BEEF : word(mem_addr);
        #1;
        c_reset = reset; c_rv = imem.req_valid; c_hs = c_rv && imem.req_ready;
        c_addr = imem.req_addr; c_rsp = imem.rsp_valid; c_data = imem.rsp_data;
        c_stall = stall; c_redir = redirect_valid; c_rpc = redirect_pc;
        if (c_reset) chk("req_valid_in_reset", {64'h0, c_rv}, 65'h0);
        else begin
            if (held || mem_busy) chk("no_second_request", {64'h0, c_rv}, 65'h0);
            if (c_rv) chk("req_addr", {33'h0, c_addr}, {33'h0, exp_pc});
        end
        @(posedge clk);
        #1;
        if (c_reset) mem_busy = 0;
        else begin
            if (c_rsp && mem_busy) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (c_hs) begin mem_busy = 1; mem_cnt = lat - 1; mem_addr = c_addr; end
        end
        if (c_reset) begin
            exp_pc = 32'h0; good = 0; held = 0; exp_if = bubble(32'h0);
        end else begin
            arrived = c_rsp && good;
            if (c_rsp) good = 0;
            if (c_hs) good = 1;
            if (c_redir) begin
                exp_if = bubble(exp_pc); exp_pc = c_rpc & ~32'h3; good = 0; held = 0;
            end else if (!c_stall && (arrived || held)) begin
                exp_if = '{pc: exp_pc, fetched_inst: held ? held_w : c_data, do_not_execute: 1'b0};
                exp_pc = exp_pc + 32'd4; held = 0;
            end else if (c_stall) begin
                if (arrived) begin held = 1; held_w = c_data; end
            end else exp_if = bubble(exp_pc);
        end
        chk("if_id_r", if_id_r, exp_if);
    endtask

    task automatic do_reset();
        reset = 1; redirect_valid = 0; stall = 0; ready_c = 1; spur_c = 0; ovr_c = 0; lat = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic wait_deliver();
        for (int i = 0; i < 30 && if_id_r.do_not_execute; i++) step();
    endtask

    initial begin
        imem.req_ready = 0; imem.rsp_valid = 0; imem.rsp_data = 0;
        do_reset();
        chk("reset_if_id", if_id_r, {32'h0, NOP_INST, 1'b1});
        step(); chk("s1_bubble0", if_id_r, {32'h0, NOP_INST, 1'b1});
        step(); chk("s1_inst0", if_id_r, {32'h0, 32'h0050_0093, 1'b0});
        step(); chk("s1_bubble1", if_id_r, {32'h4, NOP_INST, 1'b1});
        step(); chk("s1_inst1", if_id_r, {32'h4, 32'h00A0_0113, 1'b0});

        do_reset();
        step();
        stall = 1;
        step(); step(); step();
        chk("s2_hold_no_req", {64'h0, imem.req_valid}, 65'h0);
        chk("s2_held_if", if_id_r, {32'h0, NOP_INST, 1'b1});
        stall = 0;
        step(); chk("s2_release", if_id_r, {32'h0, 32'h0050_0093, 1'b0});

        do_reset();
        lat = 3;
        step();
        ovr_c = 1;
        redirect_valid = 1; redirect_pc = 32'h100;
        step();
        redirect_valid = 0;
        step(); step();
        ovr_c = 0;
        wait_deliver();
        chk("s3_redirect_deliver", if_id_r, {32'h100, 32'h1357_9ADF, 1'b0});

        do_reset();
        lat = 2;
        redirect_valid = 1; redirect_pc = 32'h203;
        step();
        redirect_valid = 0;
        for (int i = 0; i < 10 && !imem.req_valid; i++) step();
        chk("s4_req_valid", {64'h0, imem.req_valid}, 65'h1);
        chk("s4_aligned_addr", {33'h0, imem.req_addr}, {33'h0, 32'h200});
        wait_deliver();
        chk("s4_deliver", if_id_r, {32'h200, 32'h1357_99DF, 1'b0});

        do_reset();
        ready_c = 0;
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 0; ready_c = 1;
        wait_deliver();
        chk("s5_top_word", if_id_r, {32'hFFFF_FFFC, 32'hECA8_6423, 1'b0});
        chk("s5_wrap_addr", {33'h0, imem.req_addr}, 65'h0);

        do_reset();
        ready_c = 0;
        for (int i = 0; i < 5; i++) begin
            spur_c = (i == 1 || i == 2);
            step();
            chk("s6_addr_stable", {33'h0, imem.req_addr}, 65'h0);
            chk("s6_bubble", {64'h0, if_id_r.do_not_execute}, 65'h1);
        end
        spur_c = 0; ready_c = 1;
        wait_deliver();
        chk("s6_deliver", if_id_r, {32'h0, 32'h0050_0093, 1'b0});

        do_reset();
        for (int i = 0; i < 60; i++) begin
            stall = (i % 5 == 3) || (i % 7 == 0);
            ready_c = (i % 4 != 1);
            lat = 1 + i % 3;
            redirect_valid = (i == 20 || i == 41);
            redirect_pc = 32'h40 + i * 8;
            step();
        end
        stall = 0; redirect_valid = 0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
